// File: rtl/rotate_left32_pipe_pkg.sv
// Shared constants and the per-stage conditional rotate used by every
// stage of the rotate-left pipeline.
package rotate_left32_pipe_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned AMT_W      = 5;
  localparam int unsigned PIPE_DEPTH = 5;

  // Top half of {data, data} << shift is data rotated left by shift (shift < DATA_W).
  function automatic logic [DATA_W-1:0] rotl_stage(
    input logic [DATA_W-1:0] data,
    input logic              enable,
    input int unsigned       shift
  );
    logic [2*DATA_W-1:0] dbl;
    dbl = {data, data} << shift;
    return enable ? dbl[2*DATA_W-1:DATA_W] : data;
  endfunction

endpackage

// File: rtl/rotate_left32_pipe_stage.sv
// One pipeline stage: conditional rotate-left by a fixed SHIFT, selected by
// amt bit STAGE_BIT, plus the valid/data/amt/tag holding register.
module rotl_stage_reg #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned AMT_W     = 5,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned SHIFT     = 1,
  parameter int unsigned STAGE_BIT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adv,
  input  logic              prev_valid,
  input  logic [DATA_W-1:0] prev_data,
  input  logic [AMT_W-1:0]  prev_amt,
  input  logic [TAG_W-1:0]  prev_tag,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [AMT_W-1:0]  amt,
  output logic [TAG_W-1:0]  tag
);
  import rotate_left32_pipe_pkg::*;

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [AMT_W-1:0]  amt_q;
  logic [TAG_W-1:0]  tag_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      tag_q   <= '0;
    end else if (adv) begin
      valid_q <= prev_valid;
      data_q  <= rotl_stage(prev_data, prev_amt[STAGE_BIT], SHIFT);
      amt_q   <= prev_amt;
      tag_q   <= prev_tag;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign amt   = amt_q;
  assign tag   = tag_q;

endmodule

// File: rtl/rotate_left32_pipe.sv
// Five-stage pipelined 32-bit rotate-left with valid/ready on both ends and
// a sideband tag that travels alongside each operand.
module rotate_left32_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = 5,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic [TAG_W-1:0]  out_tag
);
  import rotate_left32_pipe_pkg::*;

  if (DATA_W != rotate_left32_pipe_pkg::DATA_W || AMT_W != rotate_left32_pipe_pkg::AMT_W)
  begin : gen_width_check
    $error("rotate_left32_pipe supports only DATA_W = 32 and AMT_W = 5");
  end

  logic              valid_s [PIPE_DEPTH];
  logic [DATA_W-1:0] data_s  [PIPE_DEPTH];
  logic [AMT_W-1:0]  amt_s   [PIPE_DEPTH];
  logic [TAG_W-1:0]  tag_s   [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] adv;

  // A stage may load when it is empty or its occupant moves on this cycle,
  // so bubbles are squeezed out while the output is stalled.
  always_comb begin
    adv = '0;
    adv[PIPE_DEPTH-1] = out_ready || !valid_s[PIPE_DEPTH-1];
    for (int k = PIPE_DEPTH - 2; k >= 0; k--) begin
      adv[k] = adv[k+1] || !valid_s[k];
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : gen_stage
    logic              pv;
    logic [DATA_W-1:0] pd;
    logic [AMT_W-1:0]  pa;
    logic [TAG_W-1:0]  pt;

    if (k == 0) begin : gen_head
      assign pv = in_valid && in_ready;
      assign pd = a;
      assign pa = amt;
      assign pt = in_tag;
    end else begin : gen_body
      assign pv = valid_s[k-1];
      assign pd = data_s[k-1];
      assign pa = amt_s[k-1];
      assign pt = tag_s[k-1];
    end

    rotl_stage_reg #(
      .DATA_W   (DATA_W),
      .AMT_W    (AMT_W),
      .TAG_W    (TAG_W),
      .SHIFT    (1 << k),
      .STAGE_BIT(k)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .adv       (adv[k]),
      .prev_valid(pv),
      .prev_data (pd),
      .prev_amt  (pa),
      .prev_tag  (pt),
      .valid     (valid_s[k]),
      .data      (data_s[k]),
      .amt       (amt_s[k]),
      .tag       (tag_s[k])
    );
  end

  // The amount is fully consumed by the last stage.
  logic [AMT_W-1:0] unused_amt;
  assign unused_amt = amt_s[PIPE_DEPTH-1];

  assign out_valid = valid_s[PIPE_DEPTH-1];
  assign y         = data_s[PIPE_DEPTH-1];
  assign out_tag   = tag_s[PIPE_DEPTH-1];

endmodule

// File: tb/tb_rotate_left32_pipe.sv
// Self-checking bench for rotate_left32_pipe: directed cases, streaming,
// backpressure, mid-flight reset and a randomised scoreboard run.
module tb_rotate_left32_pipe;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  amt;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic [3:0]  out_tag;

  rotate_left32_pipe u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .amt      (amt),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .out_tag  (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  logic [35:0] exp_q[$];
  logic        accepted;
  logic        emitted;
  int          cyc;
  logic        hold_pending;
  logic [31:0] hold_y;
  logic [3:0]  hold_tag;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Rotate-left expressed as a rotate-right by (32 - amt) mod 32 on a doubled word.
  function automatic logic [31:0] rotl_model(input logic [31:0] av, input logic [4:0] mv);
    int unsigned r;
    logic [63:0] dbl;
    r   = (32 - int'(mv)) % 32;
    dbl = {av, av} >> r;
    return dbl[31:0];
  endfunction

  task automatic step(input logic iv, input logic [31:0] av, input logic [4:0] mv,
                      input logic [3:0] tv, input logic orv);
    logic [35:0] e;
    @(posedge clk);
    #1;
    in_valid  = iv;
    a         = av;
    amt       = mv;
    in_tag    = tv;
    out_ready = orv;
    @(negedge clk);
    cyc++;
    accepted = in_valid && in_ready;
    emitted  = out_valid && out_ready;
    if (hold_pending) begin
      check_eq("hold_valid", {31'b0, out_valid}, 32'd1);
      check_eq("hold_y", y, hold_y);
      check_eq("hold_tag", {28'b0, out_tag}, {28'b0, hold_tag});
    end
    if (emitted) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_y", y, e[31:0]);
        check_eq("sb_tag", {28'b0, out_tag}, {28'b0, e[35:32]});
      end
    end
    if (accepted) exp_q.push_back({tv, rotl_model(av, mv)});
    hold_pending = out_valid && !out_ready;
    hold_y       = y;
    hold_tag     = out_tag;
  endtask

  task automatic directed(input logic [31:0] av, input logic [4:0] mv, input logic [3:0] tv,
                          input logic [31:0] ey, input string nm);
    int lat;
    bit seen;
    step(1'b1, av, mv, tv, 1'b1);
    check_eq({nm, "_accept"}, {31'b0, accepted}, 32'd1);
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
      lat++;
      if (emitted) begin
        seen = 1;
        check_eq({nm, "_y"}, y, ey);
        check_eq({nm, "_tag"}, {28'b0, out_tag}, {28'b0, tv});
      end
    end
    check_eq({nm, "_latency"}, lat, 32'd5);
  endtask

  initial begin
    logic [31:0] bp_a   [9];
    logic [4:0]  bp_amt [9];
    int idx, nout, nacc, first_out, last_out;

    n_checks = 0; n_fail = 0; cyc = 0; hold_pending = 0;
    reset_n = 1'b0; in_valid = 1'b0; a = '0; amt = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("rst_y", y, 32'd0);
    check_eq("rst_tag", {28'b0, out_tag}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    directed(32'h80000001, 5'd1,  4'd3, 32'h00000003, "basic1");
    directed(32'h12345678, 5'd8,  4'd5, 32'h34567812, "basic8");
    directed(32'hDEADBEEF, 5'd0,  4'd6, 32'hDEADBEEF, "amt0");
    directed(32'h00000001, 5'd31, 4'd7, 32'h80000000, "amt31");
    directed(32'hFFFF0000, 5'd16, 4'd9, 32'h0000FFFF, "amt16");

    // Back-to-back stream of 32 operands.
    nout = 0; nacc = 0; first_out = -1; last_out = -1;
    for (int i = 0; i < 60; i++) begin
      if (i < 32) step(1'b1, 32'h1, 5'(i), 4'(i), 1'b1);
      else        step(1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
      if (accepted) nacc++;
      if (emitted) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        nout++;
      end
    end
    check_eq("b2b_accepted", nacc, 32'd32);
    check_eq("b2b_outputs", nout, 32'd32);
    check_eq("b2b_no_gaps", last_out - first_out, 32'd31);

    // Backpressure: only five fit while the output is stalled.
    for (int i = 0; i < 9; i++) begin
      bp_a[i]   = $urandom;
      bp_amt[i] = 5'(i * 3 + 1);
    end
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, bp_a[idx], bp_amt[idx], 4'(idx + 8), 1'b0);
      if (accepted) idx++;
    end
    check_eq("bp_accepted_stalled", idx, 32'd5);
    check_eq("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    check_eq("bp_out_valid_full", {31'b0, out_valid}, 32'd1);
    nout = 0;
    for (int i = 0; i < 40; i++) begin
      step(idx < 8, bp_a[idx], bp_amt[idx], 4'(idx + 8), 1'b1);
      if (accepted) idx++;
      if (emitted) nout++;
    end
    check_eq("bp_total_accepted", idx, 32'd8);
    check_eq("bp_total_out", nout, 32'd8);

    // Reset with three operands in flight.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 5'($urandom), 4'(i), 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.delete();
    hold_pending = 0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("mid_rst_y", y, 32'd0);
    check_eq("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    nout = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
      if (emitted) nout++;
    end
    check_eq("mid_rst_no_stale", nout, 32'd0);

    // Randomised run against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 4'($urandom),
           1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, 32'h0, 5'd0, 4'd0, 1'b1);
    check_eq("drain_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
